// File: rtl/siso_pkg.sv
// Shared constants for the serial-in serial-out shift register.
// Holds the legal DEPTH range so the top can reject bad parameters
// at elaboration instead of building a malformed chain.
package siso_pkg;

   localparam int SISO_DEPTH_MIN = 1;
   localparam int SISO_DEPTH_MAX = 32;

endpackage

// File: rtl/siso_dff.sv
// One stage of the shift chain: rising-edge D flip-flop with an
// asynchronous, active-high clear.
//   CLK  in   rising-edge clock
//   RST  in   asynchronous clear, active high
//   D    in   data captured on CLK rising edge
//   Q    out  registered data
module siso_dff (
   input  logic CLK,
   input  logic RST,
   input  logic D,
   output logic Q
);

   logic r_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_q <= 1'b0;
      end else begin
         r_q <= D;
      end
   end

   assign Q = r_q;

endmodule

// File: rtl/siso.sv
// Serial-in serial-out shift register of DEPTH stages.
// Each rising CLK edge captures SI into stage 0 and moves every stored
// bit one stage toward the output; a bit reaches Q0 DEPTH edges after
// (and including) its capture edge.
//   CLK  in   rising-edge clock for every stage
//   SI   in   serial data in
//   Q0   out  last stage (stage DEPTH-1)
//   RST  in   asynchronous clear, active high (tie low if unused)
//   Q    out  all stages, Q[0] newest, Q[DEPTH-1] == Q0
// Port order keeps legacy three-port positional hookups (CLK, SI, Q0)
// connecting correctly.
module siso
   import siso_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             CLK,
   input  logic             SI,
   output logic             Q0,
   input  logic             RST,
   output logic [DEPTH-1:0] Q
);

   if (DEPTH < SISO_DEPTH_MIN || DEPTH > SISO_DEPTH_MAX) begin : g_bad_depth
      $error("siso: DEPTH out of range 1..32");
   end

   logic [DEPTH-1:0] w_stage;

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_head
         siso_dff u_dff (
            .CLK (CLK),
            .RST (RST),
            .D   (SI),
            .Q   (w_stage[g])
         );
      end else begin : g_body
         siso_dff u_dff (
            .CLK (CLK),
            .RST (RST),
            .D   (w_stage[g-1]),
            .Q   (w_stage[g])
         );
      end
   end

   assign Q  = w_stage;
   assign Q0 = w_stage[DEPTH-1];

endmodule

// File: tb/tb_siso.sv
module tb_siso;

   logic       clk_sys;
   logic       rst;
   logic       si;
   logic       q0_1;
   logic       q0_4;
   logic       q0_8;
   logic [0:0] q_1;
   logic [3:0] q_4;
   logic [7:0] q_8;

   int n_tests = 0;
   int n_fail  = 0;

   // Scoreboards hold the last DEPTH captured bits, oldest at the front.
   bit sb1[$];
   bit sb4[$];
   bit sb8[$];

   siso #(.DEPTH(1)) u_d1 (.CLK(clk_sys), .SI(si), .Q0(q0_1), .RST(rst), .Q(q_1));
   siso #(.DEPTH(4)) u_d4 (.CLK(clk_sys), .SI(si), .Q0(q0_4), .RST(rst), .Q(q_4));
   siso #(.DEPTH(8)) u_d8 (.CLK(clk_sys), .SI(si), .Q0(q0_8), .RST(rst), .Q(q_8));

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   initial begin
      #200000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] vec_of(input bit q[$]);
      logic [31:0] v = '0;
      for (int i = 0; i < q.size(); i++) v[i] = q[q.size()-1-i];
      return v;
   endfunction

   task automatic model_clear();
      sb1 = {};
      sb4 = {};
      sb8 = {};
      repeat (1) sb1.push_back(1'b0);
      repeat (4) sb4.push_back(1'b0);
      repeat (8) sb8.push_back(1'b0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_q1"}, {31'b0, q_1}, 32'h0);
      check({tag, "_q4"}, {28'b0, q_4}, 32'h0);
      check({tag, "_q8"}, {24'b0, q_8}, 32'h0);
      check({tag, "_q0_4"}, {31'b0, q0_4}, 32'h0);
   endtask

   // Starts at a falling edge with rst high; ends at a falling edge with rst low.
   task automatic do_reset();
      rst = 1'b1;
      si  = 1'b1;
      #1;
      check_all_zero("rst_imm");
      repeat (3) begin
         @(posedge clk_sys);
         #1;
         check_all_zero("rst_hold");
      end
      @(negedge clk_sys);
      rst = 1'b0;
      model_clear();
   endtask

   // Called at a falling edge; drives one bit, checks after the rising edge,
   // returns at the next falling edge.
   task automatic shift_bit(input logic b);
      si = b;
      @(posedge clk_sys);
      sb1.push_back(b); void'(sb1.pop_front());
      sb4.push_back(b); void'(sb4.pop_front());
      sb8.push_back(b); void'(sb8.pop_front());
      #1;
      check("d1_q0", {31'b0, q0_1}, {31'b0, sb1[0]});
      check("d1_q",  {31'b0, q_1},  vec_of(sb1));
      check("d4_q0", {31'b0, q0_4}, {31'b0, sb4[0]});
      check("d4_q",  {28'b0, q_4},  vec_of(sb4));
      check("d8_q0", {31'b0, q0_8}, {31'b0, sb8[0]});
      check("d8_q",  {24'b0, q_8},  vec_of(sb8));
      check("d8_qtop", {31'b0, q_8[7]}, {31'b0, sb8[0]});
      @(negedge clk_sys);
   endtask

   logic [15:0] pat;
   logic [5:0]  pat6;

   initial begin
      rst = 1'b1;
      si  = 1'b1;
      do_reset();

      // Single pulse captured at edge 35.
      for (int k = 0; k < 6; k++) begin
         shift_bit(k == 0);
         check("pulse_q4", {28'b0, q_4}, (k < 4) ? (32'h1 << k) : 32'h0);
         check("pulse_q0", {31'b0, q0_4}, (k == 3) ? 32'h1 : 32'h0);
         check("pulse_d1", {31'b0, q0_1}, (k == 0) ? 32'h1 : 32'h0);
      end
      repeat (4) shift_bit(1'b0);
      check("pulse_d8_late", {31'b0, q0_8}, 32'h0);

      // Pattern 0,0,0,1,1,0 then zeros.
      do_reset();
      pat6 = 6'b000110;
      for (int k = 5; k >= 0; k--) shift_bit(pat6[k]);
      check("pat_q4", {28'b0, q_4}, 32'h6);
      check("pat_q0_a", {31'b0, q0_4}, 32'h0);
      shift_bit(1'b0);
      check("pat_q0_b", {31'b0, q0_4}, 32'h1);
      shift_bit(1'b0);
      check("pat_q0_c", {31'b0, q0_4}, 32'h1);
      shift_bit(1'b0);
      check("pat_q0_d", {31'b0, q0_4}, 32'h0);

      // Full stream, MSB first, then flush with zeros.
      pat = 16'hA5C3;
      for (int k = 15; k >= 0; k--) shift_bit(pat[k]);
      repeat (8) shift_bit(1'b0);

      // Mid-stream reset with all-ones loaded.
      repeat (8) shift_bit(1'b1);
      check("ones_q4", {28'b0, q_4}, 32'hF);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("mid_rst_imm");
      #4;
      check_all_zero("mid_rst_edge");
      rst = 1'b0;
      @(negedge clk_sys);
      model_clear();
      for (int k = 0; k < 9; k++) begin
         shift_bit(1'b0);
         check("mid_rst_q0_4", {31'b0, q0_4}, 32'h0);
         check("mid_rst_q0_8", {31'b0, q0_8}, 32'h0);
      end

      // Random stream against the scoreboard.
      for (int k = 0; k < 40; k++) shift_bit(1'($urandom_range(0, 1)));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
